wb_retire_unit: RTL and testbench
=================================

Name: wb_retire_unit

Overview:
- Writeback/retire stage at the consuming end of the execute-2 to writeback interface of the scalar/vector pipeline.
- Accepts one completed instruction per cycle from execute-2 and performs the matching action:
  - commits scalar results to the scalar register file;
  - sequences vector results into the single-lane vector register write port, one lane per cycle, back-pressuring execute-2 while it does so;
  - resolves conditional jumps into flush/redirect;
  - latches halt.

Parameters:
- VLEN, 4, vector lanes per vector register (power of two, >=2).
- LANE_W, 2, lane index width, equal to log2(VLEN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- x2_valid  in  1  execute-2 holds a valid instruction.
- x2_pc  in  16  PC of that instruction.
- x2_ins  in  16  instruction: opcode [15:12], subcode [7:4], rt [3:0].
- x2_result  in  16  scalar result (ALU, movl/movh, ld data, vdot).
- x2_vresult  in  16*VLEN  vector result; lane i is bits [16i+15:16i].
- x2_cond_val  in  16  jump condition operand.
- x2_target  in  16  jump target PC.
- wb_stall  out  1  execute-2 must hold its instruction.
- reg_we  out  1  scalar register file write enable.
- reg_waddr  out  4  scalar write address.
- reg_wdata  out  16  scalar write data.
- vreg_we  out  1  vector register file write enable.
- vreg_waddr  out  4  vector register number.
- vreg_lane  out  LANE_W  lane being written.
- vreg_wdata  out  16  lane data.
- flush  out  1  one-cycle pulse: squash younger instructions.
- redirect_pc  out  16  new fetch PC; valid while flush=1.
- halt  out  1  sticky halt.
- retired_count  out  16  retired-instruction counter.

Behaviour:
- Opcodes:
  - 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 movl, 0101 movh.
  - 0110 jmp: subcode 0 jz, 1 jnz, 2 js, 3 jns.
  - 0111 scalar mem: subcode 0 ld, 1 st.
  - 1000–1011 vadd/vsub/vmul/vdiv, 1100 vld, 1101 vst, 1110 vdot, 1111 halt.
- Accept condition: x2_valid && !wb_stall && !halt, evaluated at a rising edge.
- Reset (async): all outputs 0 (redirect_pc=0, retired_count=0), state=IDLE, lane counter 0, vector buffer cleared. A vector write in progress is abandoned; no further lanes are written.
- State machine IDLE / VWRITE.
  - IDLE: wb_stall=0.
  - Scalar-writing op accepted (add, sub, mul, div, movl, movh, ld, vdot):
    - Next cycle: reg_we=1, reg_waddr=rt, reg_wdata=x2_result, for exactly one cycle.
    - rt==0: reg_we stays 0 (r0 is hardwired).
  - Vector-writing op accepted (vadd, vsub, vmul, vdiv, vld):
    - At the accept edge: capture x2_vresult and rt; go to VWRITE with lane=0.
  - st, vst, non-taken jumps, unknown jmp subcodes: retire with no register write.
- VWRITE:
  - vreg_we=1, vreg_waddr=captured rt, vreg_lane=lane, vreg_wdata=buffer lane[lane]. These outputs are driven from registered state.
  - wb_stall = (lane != VLEN-1).
  - Each edge increments lane.
  - At the edge ending lane VLEN-1, a new instruction may be accepted in the same edge (back-to-back). The state becomes IDLE, or VWRITE again if the new instruction is a vector op.
  - A vector op occupies exactly VLEN cycles of vreg_we. v0 is writable.
- Jumps:
  - Taken conditions: jz if cond==0; jnz if cond!=0; js if cond[15]=1; jns if cond[15]=0.
  - Taken: cycle after accept, flush=1 for one cycle and redirect_pc=x2_target.
  - Not taken: flush=0.
  - redirect_pc holds its last value when flush=0.
- Halt: cycle after accept, halt=1, sticky until rst. Subsequent x2_valid is ignored; no writes, no counting.
- retired_count: +1 on every accepted instruction, including halt. A vector op counts once, at acceptance. Wraps FFFF -> 0000.
- At most one of reg_we / flush / halt-rise results per accepted instruction.
- vreg_we may overlap reg_we from an instruction accepted at the final-lane edge.

Test Plan:
- add rt=3, x2_result=0x1234 accepted -> next cycle reg_we=1, waddr=3, wdata=0x1234 for one cycle; retired_count=1.
- movl rt=0, result=0x00FF -> reg_we stays 0; retired_count increments.
- vadd rt=5 with VLEN=4, lanes 0x11,0x22,0x33,0x44, followed immediately by add rt=2 held valid:
  - vreg_we=1 for 4 cycles, lanes 0..3 in order with data 0x11..0x44.
  - wb_stall=1 for the first 3 of those cycles.
  - The add is accepted at the final-lane edge; its reg_we appears the next cycle.
- jz cond=0, target=0x0040 -> flush pulse of 1 cycle with redirect_pc=0x0040.
- jnz cond=0 -> flush stays 0.
- js cond=0x8000 -> flush.
- halt then add valid -> halt=1 sticky, add never written, retired_count frozen.
- Async rst asserted mid-VWRITE after lane 1 -> immediately vreg_we=0, wb_stall=0, count=0; lanes 2–3 are never written after release.
- Counter preloaded by 65535 accepted nops (st) -> next accept wraps retired_count to 0.

Source files
------------

// File: rtl/wb_retire_unit.sv
// wb_retire_unit
//   Writeback/retire stage at the consuming end of the execute-2 to writeback
//   interface. It accepts one completed instruction per cycle. For each one it
//   either commits a scalar result, sequences a vector result one lane per
//   cycle into the single-lane vector register write port, resolves a
//   conditional jump into flush/redirect, or latches halt.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   x2_*              instruction handed over by execute-2 (valid, pc, ins,
//                     scalar/vector results, jump condition operand and target)
//   wb_stall          execute-2 must hold its instruction (vector sequencing)
//   reg_we/waddr/wdata        scalar register file write port
//   vreg_we/waddr/lane/wdata  single-lane vector register file write port
//   flush, redirect_pc        one-cycle squash pulse and the new fetch PC
//   halt              sticky halt
//   retired_count     wrapping count of accepted instructions
module wb_retire_unit #(
  parameter int VLEN   = 4,
  parameter int LANE_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x2_valid,
  input  logic [15:0]          x2_pc,
  input  logic [15:0]          x2_ins,
  input  logic [15:0]          x2_result,
  input  logic [16*VLEN-1:0]   x2_vresult,
  input  logic [15:0]          x2_cond_val,
  input  logic [15:0]          x2_target,
  output logic                 wb_stall,
  output logic                 reg_we,
  output logic [3:0]           reg_waddr,
  output logic [15:0]          reg_wdata,
  output logic                 vreg_we,
  output logic [3:0]           vreg_waddr,
  output logic [LANE_W-1:0]    vreg_lane,
  output logic [15:0]          vreg_wdata,
  output logic                 flush,
  output logic [15:0]          redirect_pc,
  output logic                 halt,
  output logic [15:0]          retired_count
);

  typedef enum logic {
    IDLE,
    VWRITE
  } state_t;

  state_t                  state, state_next;
  logic [LANE_W-1:0]       lane;
  logic [VLEN-1:0][15:0]   vbuf;
  logic [3:0]              vrt;

  logic [3:0] opcode, subcode, rt;
  logic       accept, last_lane;
  logic       is_scalar_wr, is_vector_wr, is_jmp, is_halt, jmp_taken;

  // The PC and the middle instruction field are not needed to retire.
  logic unused_ok;
  assign unused_ok = ^{x2_pc, x2_ins[11:8]};

  assign opcode  = x2_ins[15:12];
  assign subcode = x2_ins[7:4];
  assign rt      = x2_ins[3:0];

  assign is_scalar_wr = (opcode <= 4'h5)
                     || (opcode == 4'h7 && subcode == 4'h0)   // ld
                     || (opcode == 4'hE);                     // vdot
  assign is_vector_wr = (opcode >= 4'h8) && (opcode <= 4'hC);
  assign is_jmp       = (opcode == 4'h6);
  assign is_halt      = (opcode == 4'hF);

  always_comb begin
    case (subcode)
      4'h0:    jmp_taken = (x2_cond_val == 16'h0000);
      4'h1:    jmp_taken = (x2_cond_val != 16'h0000);
      4'h2:    jmp_taken = x2_cond_val[15];
      4'h3:    jmp_taken = !x2_cond_val[15];
      default: jmp_taken = 1'b0;
    endcase
  end

  assign last_lane = (lane == LANE_W'(VLEN - 1));
  // The final lane cycle does not stall, so a new instruction can be taken
  // on the same edge that retires the last lane (back-to-back vectors).
  assign wb_stall  = (state == VWRITE) && !last_lane;
  assign accept    = x2_valid && !wb_stall && !halt;

  // Vector port is a pure function of registered state.
  assign vreg_we    = (state == VWRITE);
  assign vreg_waddr = vrt;
  assign vreg_lane  = lane;
  assign vreg_wdata = vbuf[lane];

  // NOTE: the combinational half assigns its output a default first so every
  // path drives it and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (accept && is_vector_wr) state_next = VWRITE;
      VWRITE: if (last_lane) state_next = (accept && is_vector_wr) ? VWRITE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lane  <= '0;
    end else begin
      state <= state_next;
      // Wraps to 0 after the last lane, which is the start of a back-to-back op.
      lane  <= (state == VWRITE) ? lane + 1'b1 : '0;
    end
  end

  // NOTE: the lane buffer is small and is cleared on reset so an abandoned
  // vector write leaves no stale data behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vbuf <= '0;
      vrt  <= '0;
    end else if (accept && is_vector_wr) begin
      vbuf <= x2_vresult;
      vrt  <= rt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_we        <= 1'b0;
      reg_waddr     <= '0;
      reg_wdata     <= '0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      halt          <= 1'b0;
      retired_count <= '0;
    end else begin
      // r0 is hardwired, so a write to it is dropped.
      reg_we <= accept && is_scalar_wr && (rt != 4'h0);
      flush  <= accept && is_jmp && jmp_taken;
      if (accept && is_scalar_wr) begin
        reg_waddr <= rt;
        reg_wdata <= x2_result;
      end
      if (accept && is_jmp && jmp_taken) redirect_pc <= x2_target;
      if (accept && is_halt)             halt <= 1'b1;
      if (accept)                        retired_count <= retired_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_retire_unit.sv
// Directed testbench for wb_retire_unit (VLEN=4). Inputs change on the
// falling edge; outputs are checked on the falling edge after each rising edge.
module tb_wb_retire_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        x2_valid;
  logic [15:0] x2_pc, x2_ins, x2_result, x2_cond_val, x2_target;
  logic [63:0] x2_vresult;
  logic        wb_stall, reg_we, vreg_we, flush, halt;
  logic [3:0]  reg_waddr, vreg_waddr;
  logic [1:0]  vreg_lane;
  logic [15:0] reg_wdata, vreg_wdata, redirect_pc, retired_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_retire_unit #(.VLEN(4), .LANE_W(2)) dut (
    .clk(clk), .rst(rst),
    .x2_valid(x2_valid), .x2_pc(x2_pc), .x2_ins(x2_ins),
    .x2_result(x2_result), .x2_vresult(x2_vresult),
    .x2_cond_val(x2_cond_val), .x2_target(x2_target),
    .wb_stall(wb_stall),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .vreg_we(vreg_we), .vreg_waddr(vreg_waddr), .vreg_lane(vreg_lane),
    .vreg_wdata(vreg_wdata),
    .flush(flush), .redirect_pc(redirect_pc),
    .halt(halt), .retired_count(retired_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: rising edge (DUT acts), then falling edge (bench looks).
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [15:0] ins, input logic [15:0] res);
    x2_valid  = 1'b1;
    x2_ins    = ins;
    x2_result = res;
  endtask

  task automatic check_lane(input string tag, input logic [1:0] ln,
                            input logic [15:0] data, input logic stall);
    check({tag, " vreg_we"},    vreg_we,    1);
    check({tag, " vreg_waddr"}, vreg_waddr, 5);
    check({tag, " vreg_lane"},  vreg_lane,  ln);
    check({tag, " vreg_wdata"}, vreg_wdata, data);
    check({tag, " wb_stall"},   wb_stall,   stall);
  endtask

  int vwrites;

  initial begin
    rst = 1'b1;
    x2_valid = 0; x2_pc = 16'h0100; x2_ins = 0; x2_result = 0;
    x2_vresult = 0; x2_cond_val = 0; x2_target = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst wb_stall", wb_stall, 0);
    check("rst reg_we", reg_we, 0);
    check("rst vreg_we", vreg_we, 0);
    check("rst flush", flush, 0);
    check("rst redirect_pc", redirect_pc, 0);
    check("rst halt", halt, 0);
    check("rst count", retired_count, 0);
    rst = 1'b0;
    step();

    // add r3 <- 0x1234
    issue(16'h0003, 16'h1234);
    step();
    check("add reg_we", reg_we, 1);
    check("add reg_waddr", reg_waddr, 3);
    check("add reg_wdata", reg_wdata, 16'h1234);
    check("add count", retired_count, 1);
    x2_valid = 0;
    step();
    check("add reg_we one cycle", reg_we, 0);

    // movl r0: dropped write, still retires
    issue(16'h4000, 16'h00FF);
    step();
    check("movl r0 reg_we", reg_we, 0);
    check("movl r0 count", retired_count, 2);
    x2_valid = 0;
    step();

    // vadd v5 followed by add r2 held valid
    issue(16'h8005, 16'h0000);
    x2_vresult = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    step();
    check("vadd count", retired_count, 3);
    check_lane("lane0", 0, 16'h0011, 1);
    issue(16'h0002, 16'hBEEF);
    step();
    check_lane("lane1", 1, 16'h0022, 1);
    step();
    check_lane("lane2", 2, 16'h0033, 1);
    step();
    check_lane("lane3", 3, 16'h0044, 0);
    check("held add not yet accepted", retired_count, 3);
    check("no reg_we during vwrite", reg_we, 0);
    step();
    check("after vadd vreg_we", vreg_we, 0);
    check("b2b add reg_we", reg_we, 1);
    check("b2b add reg_waddr", reg_waddr, 2);
    check("b2b add reg_wdata", reg_wdata, 16'hBEEF);
    check("b2b add count", retired_count, 4);
    x2_valid = 0;
    step();

    // jz taken
    issue(16'h6000, 16'h0000);
    x2_cond_val = 16'h0000; x2_target = 16'h0040;
    step();
    check("jz flush", flush, 1);
    check("jz redirect_pc", redirect_pc, 16'h0040);
    check("jz count", retired_count, 5);
    check("jz reg_we", reg_we, 0);
    x2_valid = 0;
    step();
    check("jz flush one cycle", flush, 0);
    check("jz redirect hold", redirect_pc, 16'h0040);

    // jnz not taken
    issue(16'h6010, 16'h0000);
    x2_cond_val = 16'h0000; x2_target = 16'h1111;
    step();
    check("jnz flush", flush, 0);
    check("jnz redirect hold", redirect_pc, 16'h0040);
    check("jnz count", retired_count, 6);

    // js taken on negative operand
    issue(16'h6020, 16'h0000);
    x2_cond_val = 16'h8000; x2_target = 16'h0080;
    step();
    check("js flush", flush, 1);
    check("js redirect_pc", redirect_pc, 16'h0080);
    x2_valid = 0;
    step();

    // async reset during a vector write, after lane 1
    issue(16'h8005, 16'h0000);
    x2_vresult = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    step();
    x2_valid = 0;
    step();
    check_lane("pre-rst lane1", 1, 16'hBBBB, 1);
    #1 rst = 1'b1;
    #1;
    check("async rst vreg_we", vreg_we, 0);
    check("async rst wb_stall", wb_stall, 0);
    check("async rst count", retired_count, 0);
    check("async rst redirect_pc", redirect_pc, 0);
    @(negedge clk);
    rst = 1'b0;
    vwrites = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (vreg_we) vwrites++;
    end
    check("abandoned lanes written", vwrites, 0);

    // counter wrap through 65536 accepted st ops
    issue(16'h7010, 16'h0000);
    repeat (65535) step();
    check("count at FFFF", retired_count, 16'hFFFF);
    check("st reg_we", reg_we, 0);
    step();
    check("count wraps", retired_count, 16'h0000);
    x2_valid = 0;
    step();

    // halt, then an add that must be ignored
    issue(16'hF000, 16'h0000);
    step();
    check("halt set", halt, 1);
    check("halt count", retired_count, 1);
    issue(16'h0001, 16'h5555);
    repeat (4) step();
    check("halt sticky", halt, 1);
    check("post-halt reg_we", reg_we, 0);
    check("post-halt count frozen", retired_count, 1);
    x2_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
